// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide engine: op encoding,
// FSM states and the default operand width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// the sign correction of product, quotient and remainder.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine feeding HILO, with stall request and cancel.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   operand_b;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH:0]     remainder;
    logic [2*WIDTH-1:0] product;
    logic               is_div;
    logic               neg_result;
    logic               neg_rem;

    logic               op_signed, sign_a, sign_b, accept, fast_mul;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     div_shift, div_diff, mul_sum;
    logic               div_fits;
    logic [2*WIDTH-1:0] prod_src, prod_fixed;
    logic               prod_neg;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = op_signed & a[WIDTH-1];
    assign sign_b    = op_signed & b[WIDTH-1];
    assign accept    = (state == IDLE) & start & ~cancel;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.value(a), .negate(sign_a), .result(abs_a));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.value(b), .negate(sign_b), .result(abs_b));

    // Restoring division step; a set top bit means the shifted value already exceeds the divisor.
    assign div_shift = {remainder[WIDTH-1:0], quotient[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, operand_b};
    assign div_fits  = remainder[WIDTH] | (div_shift >= {1'b0, operand_b});

    assign mul_sum = {1'b0, product[2*WIDTH-1:WIDTH]}
                   + (product[0] ? {1'b0, operand_b} : '0);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = accept & ~op[1];
    assign prod_src = fast_mul ? ({{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b}) : product;
    assign prod_neg = fast_mul ? (sign_a ^ sign_b) : neg_result;
`else
    assign fast_mul = 1'b0;
    assign prod_src = product;
    assign prod_neg = neg_result;
`endif

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_prod_fix (.value(prod_src), .negate(prod_neg), .result(prod_fixed));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_quot_fix (.value(quotient), .negate(neg_result), .result(quot_fixed));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (.value(remainder[WIDTH-1:0]), .negate(neg_rem), .result(rem_fixed));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast_mul ? DONE : RUN;
            RUN:     if (cancel) state_next = IDLE;
                     else if (count == '0) state_next = FIX;
            FIX:     state_next = cancel ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = accept | (state == RUN) | (state == FIX);
    assign done  = (state == DONE) & ~cancel;

    // Quotient is not negated for a zero divisor so that lo stays all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            operand_b  <= '0;
            quotient   <= '0;
            remainder  <= '0;
            product    <= '0;
            is_div     <= 1'b0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    operand_b  <= abs_b;
                    quotient   <= abs_a;
                    remainder  <= '0;
                    product    <= {{WIDTH{1'b0}}, abs_a};
                    is_div     <= op[1];
                    neg_result <= (sign_a ^ sign_b) & (|b);
                    neg_rem    <= sign_a;
                    count      <= CW'(WIDTH - 1);
                    if (fast_mul) {hi, lo} <= prod_fixed;
                end
                RUN: if (!cancel) begin
                    if (count != '0) count <= count - 1'b1;
                    if (is_div) begin
                        remainder <= div_fits ? div_diff : div_shift;
                        quotient  <= {quotient[WIDTH-2:0], div_fits};
                    end else begin
                        product <= {mul_sum, product[WIDTH-1:1]};
                    end
                end
                FIX: if (!cancel) begin
                    {hi, lo} <= is_div ? {rem_fixed, quot_fixed} : prod_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-count reference model with a
// per-cycle compare process, directed literal checks and random operations.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start, cancel, busy, stall, done;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        start8, cancel8, busy8, stall8, done8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(cancel8),
        .busy(busy8), .stall(stall8), .done(done8), .hi(hi8), .lo(lo8)
    );

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic [63:0] got;
        logic [63:0] want;
    } chk_t;
    chk_t chk_q[$];

    // Result of an operation from plain integer arithmetic, packed as {hi, lo}.
    function automatic logic [63:0] ref_result(input int w, input logic [1:0] o,
                                               input logic [31:0] x, input logic [31:0] y);
        longint mask, ua, ub, sa, sb, p, q, r;
        mask = (longint'(1) << w) - 1;
        ua = longint'(x) & mask;
        ub = longint'(y) & mask;
        sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
        sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
        p = 0; q = 0; r = 0;
        case (o)
            OP_MULT:  p = sa * sb;
            OP_MULTU: p = ua * ub;
            OP_DIV:   if (ub == 0) begin q = mask; r = ua; end
                      else begin q = sa / sb; r = sa % sb; end
            default:  if (ub == 0) begin q = mask; r = ua; end
                      else begin q = ua / ub; r = ua % ub; end
        endcase
        if (!o[1]) begin
            q = p & mask;
            r = (p >> w) & mask;
        end
        return {32'(r & mask), 32'(q & mask)};
    endfunction

    function automatic int lat_of(input int w, input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return w + 2;
    endfunction

    // Reference model for the 32-bit unit: cycles since acceptance and held results.
    logic        m_active = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_hi     <= '0;
            m_lo     <= '0;
        end else if (!m_active) begin
            if (start && !cancel) begin
                m_active <= 1'b1;
                m_cnt    <= 1;
                m_lat    <= lat_of(32, op);
                m_res    <= ref_result(32, op, a, b);
                if (lat_of(32, op) == 1) {m_hi, m_lo} <= ref_result(32, op, a, b);
            end
        end else if (cancel || m_cnt == m_lat) begin
            m_active <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) {m_hi, m_lo} <= m_res;
        end
    end

    function automatic void cmp(input string n, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", n, got, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        chk_t c;
        cmp("busy", 64'(busy), 64'(m_active));
        cmp("stall", 64'(stall), 64'(m_active ? (m_cnt < m_lat) : (start && !cancel)));
        cmp("done", 64'(done), 64'(m_active && m_cnt == m_lat && !cancel));
        cmp("hi", 64'(hi), 64'(m_hi));
        cmp("lo", 64'(lo), 64'(m_lo));
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.got, c.want);
        end
    end

    task automatic checkOutput(input string n, input logic [63:0] got, input logic [63:0] want);
        chk_q.push_back('{n, got, want});
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the edge that follows done or cancel.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input int cancel_at, output int dc,
                                 output logic [31:0] h, output logic [31:0] l);
        start = 1'b1; op = o; a = x; b = y; cancel = 1'b0;
        dc = -1; h = '0; l = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin dc = k; h = hi; l = lo; end
            @(posedge clk); #1;
            a = $urandom; b = $urandom; op = 2'($urandom);
            if (dc >= 0 || k == cancel_at) begin
                start = 1'b0; cancel = 1'b0;
                break;
            end
            start  = ($urandom_range(0, 3) == 0);
            cancel = (k + 1 == cancel_at);
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int dc, output logic [31:0] h, output logic [31:0] l);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        dc = -1; h = '0; l = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done8) begin dc = k; h = 32'(hi8); l = 32'(lo8); end
            @(posedge clk); #1;
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            if (dc >= 0) break;
        end
    endtask

    int          dc, ca;
    logic [31:0] h, l, x, y;
    logic [1:0]  o;

    initial begin
        start = 0; cancel = 0; op = 0; a = 0; b = 0;
        start8 = 0; cancel8 = 0; op8 = 0; a8 = 0; b8 = 0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_hi", 64'(hi), 64'h0);
        checkOutput("reset_lo", 64'(lo), 64'h0);
        @(posedge clk); #1;

        applyStimulus(OP_DIVU, 32'd100, 32'd7, -1, dc, h, l);
        checkOutput("divu_100_7_cycle", 64'(dc), 64'(34));
        checkOutput("divu_100_7_lo", 64'(l), 64'd14);
        checkOutput("divu_100_7_hi", 64'(h), 64'd2);

        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, dc, h, l);
        checkOutput("div_m7_2_lo", 64'(l), 64'hFFFFFFFD);
        checkOutput("div_m7_2_hi", 64'(h), 64'hFFFFFFFF);

        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, dc, h, l);
        checkOutput("div_ovf_lo", 64'(l), 64'h80000000);
        checkOutput("div_ovf_hi", 64'(h), 64'h0);

        applyStimulus(OP_DIVU, 32'h1234, 32'd0, -1, dc, h, l);
        checkOutput("divu_by0_lo", 64'(l), 64'hFFFFFFFF);
        checkOutput("divu_by0_hi", 64'(h), 64'h1234);

        applyStimulus(OP_DIV, 32'hFFFFFF00, 32'd0, -1, dc, h, l);
        checkOutput("div_by0_lo", 64'(l), 64'hFFFFFFFF);
        checkOutput("div_by0_hi", 64'(h), 64'hFFFFFF00);

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, -1, dc, h, l);
        checkOutput("mult_m2_3_cycle", 64'(dc), 64'(MUL_LAT));
        checkOutput("mult_m2_3_hi", 64'(h), 64'hFFFFFFFF);
        checkOutput("mult_m2_3_lo", 64'(l), 64'hFFFFFFFA);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'd2, -1, dc, h, l);
        checkOutput("multu_max_2_hi", 64'(h), 64'd1);
        checkOutput("multu_max_2_lo", 64'(l), 64'hFFFFFFFE);

        applyStimulus(OP_DIVU, 32'd1000, 32'd3, 10, dc, h, l);
        checkOutput("cancel_no_done", 64'(dc), 64'(-1));
        checkOutput("cancel_idle", 64'(busy), 64'h0);
        checkOutput("cancel_hold_hi", 64'(hi), 64'd1);
        checkOutput("cancel_hold_lo", 64'(lo), 64'hFFFFFFFE);

        start = 1'b1; cancel = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
        @(negedge clk);
        checkOutput("start_cancel_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        checkOutput("start_cancel_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;

        start = 1'b1; op = OP_DIV; a = $urandom; b = 32'd5;
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy), 64'h0);
        checkOutput("rst_mid_stall", 64'(stall), 64'h0);
        checkOutput("rst_mid_hilo", {hi, lo}, 64'h0);
        @(posedge clk); #1 rst = 1'b1;
        applyStimulus(OP_DIVU, 32'd9, 32'd3, -1, dc, h, l);
        checkOutput("after_rst_lo", 64'(l), 64'd3);
        checkOutput("after_rst_hi", 64'(h), 64'd0);

        repeat (24) begin
            o = 2'($urandom); x = $urandom; y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = $urandom_range(1, 15);
                default: ;
            endcase
            ca = -1;
            if (lat_of(32, o) > 2 && $urandom_range(0, 4) == 0) ca = $urandom_range(1, 33);
            applyStimulus(o, x, y, ca, dc, h, l);
            if (ca >= 0) begin
                checkOutput("rand_cancel", 64'(dc), 64'(-1));
            end else begin
                checkOutput("rand_cycle", 64'(dc), 64'(lat_of(32, o)));
                checkOutput("rand_hilo", {h, l}, ref_result(32, o, x, y));
            end
        end

        run8(OP_DIVU, 8'd200, 8'd9, dc, h, l);
        checkOutput("w8_divu_cycle", 64'(dc), 64'(10));
        checkOutput("w8_divu_lo", 64'(l), 64'd22);
        checkOutput("w8_divu_hi", 64'(h), 64'd2);
        repeat (10) begin
            o = 2'($urandom); x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) y = 32'd0;
            run8(o, x[7:0], y[7:0], dc, h, l);
            checkOutput("w8_rand_cycle", 64'(dc), 64'(lat_of(8, o)));
            checkOutput("w8_rand_hilo", {h, l}, ref_result(8, o, x, y));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
